sweep_sequencer: RTL

- Top-level tracking sequencer. Runs one full acquisition: horizontal sweep, then a move to the brightest horizontal position, then a vertical sweep, then a move to the brightest vertical position.
- Drives the HS/VS sweep enables consumed by the horizontal/vertical counters.
- Produces the servo position codes fed to the PWM generators.
- Reports the best light reading found.

---
 rtl/sweep_sequencer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sweep_sequencer.sv
// sweep_sequencer: single-acquisition light tracker.
// Sweeps the horizontal axis, parks on the brightest position, then sweeps the
// vertical axis and parks on the brightest position. It reports the best vertical
// reading on MAX_LIGHT.
// Optional build macro SWEEP_AUTO_REPEAT_EN: after each acquisition, rest for
// REST_TICKS step ticks and then start the next acquisition automatically.
module sweep_sequencer #(
  parameter int POS_W        = 8,
  parameter int POS_MAX      = 180,
  parameter int POS_HOME     = 90,
  parameter int LIGHT_W      = 12,
  parameter int SETTLE_TICKS = 16,
  parameter int LIMIT_FILT   = 4,
  parameter int REST_TICKS   = 255
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               STEP_TICK,
  input  logic [LIGHT_W-1:0] LIGHT,
  input  logic               PWM_LIMIT,
  output logic               HS,
  output logic               VS,
  output logic [POS_W-1:0]   H_POS,
  output logic [POS_W-1:0]   V_POS,
  output logic               BUSY,
  output logic               DONE,
  output logic [LIGHT_W-1:0] MAX_LIGHT
);

  localparam int LIM_W = $clog2(LIMIT_FILT + 1);
  localparam int SET_W = $clog2(SETTLE_TICKS + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] H_SWEEP = 3'd1;
  localparam logic [2:0] H_MAX   = 3'd2;
  localparam logic [2:0] V_SWEEP = 3'd3;
  localparam logic [2:0] V_MAX   = 3'd4;
  localparam logic [2:0] FINISH  = 3'd5;
`ifdef SWEEP_AUTO_REPEAT_EN
  localparam logic [2:0] REST    = 3'd6;
  localparam int REST_W = $clog2(REST_TICKS + 1);
`endif

  logic [2:0]         state_reg, state_next;
  logic [POS_W-1:0]   h_pos_reg, h_pos_next;
  logic [POS_W-1:0]   v_pos_reg, v_pos_next;
  logic [LIGHT_W-1:0] best_reg, best_next;
  logic [POS_W-1:0]   best_pos_reg, best_pos_next;
  logic               first_reg, first_next;
  logic [LIM_W-1:0]   limit_cnt_reg, limit_cnt_next;
  logic [SET_W-1:0]   settle_cnt_reg, settle_cnt_next;
  logic [LIGHT_W-1:0] max_light_reg, max_light_next;
`ifdef SWEEP_AUTO_REPEAT_EN
  logic [REST_W-1:0]  rest_cnt_reg, rest_cnt_next;
`else
  // Keeps the parameter referenced when the repeat feature is compiled out.
  logic [31:0]        unused_rest_ticks;
  assign unused_rest_ticks = 32'(REST_TICKS);
`endif

  // Shared sweep datapath: the position of whichever axis is sweeping, and the
  // best/limit values this tick's sample would produce.
  logic [POS_W-1:0]   sweep_pos;
  logic               take_sample;
  logic [LIGHT_W-1:0] best_upd;
  logic [POS_W-1:0]   best_pos_upd;
  logic [LIM_W-1:0]   limit_upd;
  logic               sweep_end;
  logic               settle_last;

  assign sweep_pos    = (state_reg == V_SWEEP) ? v_pos_reg : h_pos_reg;
  // Strictly greater keeps the earliest position on ties.
  assign take_sample  = first_reg || (LIGHT > best_reg);
  assign best_upd     = take_sample ? LIGHT : best_reg;
  assign best_pos_upd = take_sample ? sweep_pos : best_pos_reg;
  // Limit input may glitch: only LIMIT_FILT consecutive high ticks count.
  assign limit_upd    = !PWM_LIMIT ? '0 :
                        (limit_cnt_reg == LIM_W'(LIMIT_FILT)) ? limit_cnt_reg :
                        limit_cnt_reg + 1'b1;
  assign sweep_end    = (sweep_pos >= POS_W'(POS_MAX)) ||
                        (limit_upd == LIM_W'(LIMIT_FILT));
  assign settle_last  = (settle_cnt_reg == SET_W'(SETTLE_TICKS - 1));

  // Next-state and datapath decode; everything holds unless explicitly updated.
  always_comb begin
    state_next      = state_reg;
    h_pos_next      = h_pos_reg;
    v_pos_next      = v_pos_reg;
    best_next       = best_reg;
    best_pos_next   = best_pos_reg;
    first_next      = first_reg;
    limit_cnt_next  = limit_cnt_reg;
    settle_cnt_next = settle_cnt_reg;
    max_light_next  = max_light_reg;
`ifdef SWEEP_AUTO_REPEAT_EN
    rest_cnt_next   = rest_cnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        best_next      = '0;
        best_pos_next  = '0;
        first_next     = 1'b1;
        limit_cnt_next = '0;
        if (START) begin
          state_next = H_SWEEP;
          h_pos_next = '0;
        end
      end

      H_SWEEP: begin
        if (STEP_TICK) begin
          best_next      = best_upd;
          best_pos_next  = best_pos_upd;
          first_next     = 1'b0;
          limit_cnt_next = limit_upd;
          if (sweep_end) begin
            state_next      = H_MAX;
            h_pos_next      = best_pos_upd;
            settle_cnt_next = '0;
          end else begin
            h_pos_next = h_pos_reg + 1'b1;
          end
        end
      end

      H_MAX: begin
        if (STEP_TICK) begin
          if (settle_last) begin
            state_next     = V_SWEEP;
            v_pos_next     = '0;
            best_next      = '0;
            best_pos_next  = '0;
            first_next     = 1'b1;
            limit_cnt_next = '0;
          end else begin
            settle_cnt_next = settle_cnt_reg + 1'b1;
          end
        end
      end

      V_SWEEP: begin
        if (STEP_TICK) begin
          best_next      = best_upd;
          best_pos_next  = best_pos_upd;
          first_next     = 1'b0;
          limit_cnt_next = limit_upd;
          if (sweep_end) begin
            state_next      = V_MAX;
            v_pos_next      = best_pos_upd;
            settle_cnt_next = '0;
            max_light_next  = best_upd;
          end else begin
            v_pos_next = v_pos_reg + 1'b1;
          end
        end
      end

      V_MAX: begin
        if (STEP_TICK) begin
          if (settle_last) begin
            state_next = FINISH;
          end else begin
            settle_cnt_next = settle_cnt_reg + 1'b1;
          end
        end
      end

      FINISH: begin
`ifdef SWEEP_AUTO_REPEAT_EN
        state_next     = REST;
        rest_cnt_next  = '0;
        best_next      = '0;
        best_pos_next  = '0;
        first_next     = 1'b1;
        limit_cnt_next = '0;
`else
        state_next = IDLE;
`endif
      end

`ifdef SWEEP_AUTO_REPEAT_EN
      REST: begin
        best_next      = '0;
        best_pos_next  = '0;
        first_next     = 1'b1;
        limit_cnt_next = '0;
        if (STEP_TICK) begin
          if (rest_cnt_reg == REST_W'(REST_TICKS - 1)) begin
            state_next = H_SWEEP;
            h_pos_next = '0;
          end else begin
            rest_cnt_next = rest_cnt_reg + 1'b1;
          end
        end
      end
`endif

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset to the home position.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      h_pos_reg      <= POS_W'(POS_HOME);
      v_pos_reg      <= POS_W'(POS_HOME);
      best_reg       <= '0;
      best_pos_reg   <= '0;
      first_reg      <= 1'b0;
      limit_cnt_reg  <= '0;
      settle_cnt_reg <= '0;
      max_light_reg  <= '0;
`ifdef SWEEP_AUTO_REPEAT_EN
      rest_cnt_reg   <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      h_pos_reg      <= h_pos_next;
      v_pos_reg      <= v_pos_next;
      best_reg       <= best_next;
      best_pos_reg   <= best_pos_next;
      first_reg      <= first_next;
      limit_cnt_reg  <= limit_cnt_next;
      settle_cnt_reg <= settle_cnt_next;
      max_light_reg  <= max_light_next;
`ifdef SWEEP_AUTO_REPEAT_EN
      rest_cnt_reg   <= rest_cnt_next;
`endif
    end
  end

  // Status outputs decode the registered state, so they change with it.
  assign HS        = (state_reg == H_SWEEP);
  assign VS        = (state_reg == V_SWEEP);
  assign BUSY      = (state_reg != IDLE);
  assign DONE      = (state_reg == FINISH);
  assign H_POS     = h_pos_reg;
  assign V_POS     = v_pos_reg;
  assign MAX_LIGHT = max_light_reg;

endmodule
